// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED frame receive path.
//   BYTES_PER_LED / BITS_PER_LED : RGB payload geometry of one LED.
//   state_t                      : frame receiver FSM states.
//   frame_bytes(n)               : payload bytes carried by a frame of n LEDs.
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int BYTES_PER_LED = 3;
    localparam int BITS_PER_LED  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    function automatic int frame_bytes(input int n);
        return n * BYTES_PER_LED;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings the asynchronous SPI clock and MOSI lines into the clk domain.
// spiClk goes through two synchronizer flops plus a third history flop that
// produces single-cycle rise/fall strobes. MOSI uses the same two-flop depth,
// so din_o is aligned with rise_o and can be sampled on it directly.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   spi_clk_i   : raw SPI clock (async)
//   spi_in_i    : raw SPI MOSI (async)
//   din_o       : synchronized MOSI level
//   rise_o      : 1-cycle strobe on a synchronized spiClk rising edge
//   fall_o      : 1-cycle strobe on a synchronized spiClk falling edge
// -----------------------------------------------------------------------------
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic spi_clk_i,
    input  logic spi_in_i,
    output logic din_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sclk_q;
    logic [1:0] sdin_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q <= '0;
            sdin_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk_i};
            sdin_q <= {sdin_q[0], spi_in_i};
        end
    end

    assign din_o  = sdin_q[1];
    assign rise_o =  sclk_q[1] & ~sclk_q[2];
    assign fall_o = ~sclk_q[1] &  sclk_q[2];

endmodule

// File: rtl/spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver
// SPI slave (mode 0, MSB first) receiving one LED frame from the AVR host and
// presenting it as a parallel NUM_LEDS*24-bit word to the LED driver. A frame
// ends when spiClk has been idle for TIMEOUT_CYCLES clocks. A good frame is
// held pending and copied to 'data' only when the driver pulses 'update', so
// the output never changes while the driver is shifting a frame out.
//
// Optional build macro: FRAME_CHECKSUM_EN
//   defined   : frame carries a trailing XOR byte over all payload bytes; a
//               frame is only accepted when the XOR matches. The checksum byte
//               is not stored.
//   undefined : frame is exactly NUM_LEDS*3 payload bytes, no checksum logic.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   spiClk     SPI clock from host (async, <= clk/4)
//   spiIn      SPI MOSI (async)
//   spiOut     SPI MISO: MSB of the receive shift register, updated on spiClk fall
//   update     commit strobe from the LED driver
//   data       committed frame, LED0 in the top 24 bits
//   frame_ok   1-cycle pulse: good frame now pending
//   frame_err  1-cycle pulse: frame discarded
// -----------------------------------------------------------------------------
module spi_frame_receiver
    import led_pkg::*;
#(
    parameter int NUM_LEDS       = 20,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              spiClk,
    input  logic                              spiIn,
    output logic                              spiOut,
    input  logic                              update,
    output logic [NUM_LEDS*BITS_PER_LED-1:0]  data,
    output logic                              frame_ok,
    output logic                              frame_err
);

    localparam int FRAME_BYTES = frame_bytes(NUM_LEDS);
    localparam int DW          = NUM_LEDS * BITS_PER_LED;
`ifdef FRAME_CHECKSUM_EN
    localparam int EXPECTED    = FRAME_BYTES + 1;
`else
    localparam int EXPECTED    = FRAME_BYTES;
`endif
    localparam int BCW         = $clog2(FRAME_BYTES + 2);
    localparam int ICW         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BCW-1:0] EXP_CNT = BCW'(EXPECTED);
    localparam logic [BCW-1:0] FB_CNT  = BCW'(FRAME_BYTES);
    localparam logic [ICW-1:0] TO_CNT  = ICW'(TIMEOUT_CYCLES);

    // synchronized SPI inputs
    logic din, rise, fall;

    spi_sync_edge u_sync (
        .clk       (clk),
        .reset     (reset),
        .spi_clk_i (spiClk),
        .spi_in_i  (spiIn),
        .din_o     (din),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    // datapath state
    logic [2:0]     bit_cnt_q,  bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic           ovf_q,      ovf_d;
    logic [7:0]     sr_q,       sr_d;
    logic [DW-1:0]  rx_buf_q,   rx_buf_d;
    logic           spi_out_q,  spi_out_d;
    logic [ICW-1:0] idle_q,     idle_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]     csum_q,     csum_d;
    logic [7:0]     chk_q,      chk_d;
`endif

    // control state
    state_t         state_q;
    logic           pending_q;
    logic [DW-1:0]  data_q;
    logic           frame_ok_q, frame_err_q;

    logic [7:0]     byte_in;
    logic           eof;
    logic           good;

    // byte being completed if this rise carries its 8th bit
    assign byte_in = {sr_q[6:0], din};
    assign eof     = (state_q == RECV) && (idle_q == TO_CNT);

`ifdef FRAME_CHECKSUM_EN
    assign good = (bit_cnt_q == 3'd0) && (byte_cnt_q == EXP_CNT) && !ovf_q &&
                  (csum_q == chk_q);
`else
    assign good = (bit_cnt_q == 3'd0) && (byte_cnt_q == EXP_CNT) && !ovf_q;
`endif

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        ovf_d      = ovf_q;
        sr_d       = sr_q;
        rx_buf_d   = rx_buf_q;
        spi_out_d  = spi_out_q;
        idle_d     = idle_q;
`ifdef FRAME_CHECKSUM_EN
        csum_d     = csum_q;
        chk_d      = chk_q;
`endif

        // idle timer: restarted by every spiClk rise, saturates at timeout
        if (rise)
            idle_d = '0;
        else if (idle_q != TO_CNT)
            idle_d = idle_q + 1'b1;

        // MISO changes on the falling edge so the host samples it stable
        if (fall)
            spi_out_d = sr_q[7];

        if (state_q == CHECK) begin
            // frame verdict is being taken this cycle; rearm for next frame
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            ovf_d      = 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_d     = '0;
`endif
        end else if (rise) begin
            sr_d      = byte_in;
            bit_cnt_d = bit_cnt_q + 1'b1;   // wraps 7 -> 0 at byte end
            if (bit_cnt_q == 3'd7) begin
                if (byte_cnt_q == EXP_CNT) begin
                    // surplus byte: drop it, remember the frame is too long
                    ovf_d = 1'b1;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q < FB_CNT) begin
                        for (int k = 0; k < FRAME_BYTES; k++) begin
                            if (byte_cnt_q == BCW'(k))
                                rx_buf_d[DW-1-8*k -: 8] = byte_in;
                        end
`ifdef FRAME_CHECKSUM_EN
                        csum_d = csum_q ^ byte_in;
                    end else begin
                        chk_d = byte_in;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            ovf_q      <= 1'b0;
            sr_q       <= '0;
            rx_buf_q   <= '0;
            spi_out_q  <= 1'b0;
            idle_q     <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum_q     <= '0;
            chk_q      <= '0;
`endif
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            ovf_q      <= ovf_d;
            sr_q       <= sr_d;
            rx_buf_q   <= rx_buf_d;
            spi_out_q  <= spi_out_d;
            idle_q     <= idle_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q     <= csum_d;
            chk_q      <= chk_d;
`endif
        end
    end

    // Frame FSM with pending/commit handling. Commit reads rx_buf_q, i.e. the
    // contents before any byte written in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            data_q      <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (update && pending_q) begin
                data_q    <= rx_buf_q;
                pending_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rise) begin
                        // a new frame overwrites rx_buf: drop the stale pending one
                        state_q   <= RECV;
                        pending_q <= 1'b0;
                    end
                end
                RECV: begin
                    if (eof)
                        state_q <= CHECK;
                end
                CHECK: begin
                    if (good) begin
                        pending_q  <= 1'b1;
                        frame_ok_q <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spiOut    = spi_out_q;
    assign data      = data_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
module tb_spi_frame_receiver;

    localparam int NL   = 2;
    localparam int TO   = 64;
    localparam int FB   = NL * 3;
    localparam int DW   = NL * 24;
    localparam int HALF = 4;
`ifdef FRAME_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int EXP  = FB + (CSUM ? 1 : 0);

    typedef logic [7:0] byte_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          spiClk = 1'b0;
    logic          spiIn = 1'b0;
    logic          update = 1'b0;
    logic          spiOut, frame_ok, frame_err;
    logic [DW-1:0] data;

    spi_frame_receiver #(.NUM_LEDS(NL), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .spiClk    (spiClk),
        .spiIn     (spiIn),
        .spiOut    (spiOut),
        .update    (update),
        .data      (data),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            exp_q[$];      // expected frame verdicts: 1 = ok, 2 = err
    bit            hist[$];       // every MOSI bit shifted in since reset
    logic [DW-1:0] m_data;        // what the driver should currently see
    logic [DW-1:0] m_rx;          // last accepted frame payload
    bit            m_pending;
    int            mon_ev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: each verdict pulse pops one expected verdict
    always @(negedge clk) begin
        if (!reset && (frame_ok || frame_err)) begin
            mon_ev = frame_ok ? 1 : 2;
            check("ok_err_exclusive", {63'd0, frame_ok & frame_err}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_verdict: got %0d expected none", mon_ev);
            end else begin
                check("frame_verdict", 64'(mon_ev), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic model_reset();
        m_data    = '0;
        m_rx      = '0;
        m_pending = 1'b0;
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(1'b0);
    endtask

    task automatic spi_bit(input bit b, input bit upd);
        if (upd) update = 1'b1;
        spiIn = b;
        repeat (HALF) @(posedge clk);
        #1 spiClk = 1'b1;
        hist.push_back(b);
        repeat (HALF) @(posedge clk);
        #1 spiClk = 1'b0;
        if (upd) update = 1'b0;
    endtask

    // mode 0: plain; 1: update held over the first bit; 2: update held over
    // the bit that completes byte 2
    task automatic send_frame(input byte_t bytes[$], input int extra_bits, input int mode);
        int    nb;
        bit    good;
        byte_t x;
        nb = bytes.size();
        if (mode == 1 && m_pending) m_data = m_rx;
        m_pending = 1'b0;
        for (int i = 0; i < nb; i++)
            for (int b = 7; b >= 0; b--)
                spi_bit(bytes[i][b], (mode == 1 && i == 0 && b == 7) ||
                                     (mode == 2 && i == 2 && b == 0));
        for (int j = 0; j < extra_bits; j++)
            spi_bit(1'($urandom_range(1, 0)), 1'b0);
        good = (extra_bits == 0) && (nb == EXP);
        if (good && CSUM) begin
            x = 8'h00;
            for (int k = 0; k < FB; k++) x ^= bytes[k];
            good = (x == bytes[FB]);
        end
        exp_q.push_back(good ? 1 : 2);
        if (good) begin
            for (int k = 0; k < FB; k++) m_rx[DW-1-8*k -: 8] = bytes[k];
            m_pending = 1'b1;
        end
        repeat (TO + 16) @(posedge clk);
        #1;
        check("spiOut", {63'd0, spiOut}, {63'd0, hist[hist.size()-8]});
        check("data_held", 64'(data), 64'(m_data));
    endtask

    task automatic do_update();
        @(posedge clk);
        #1 update = 1'b1;
        @(posedge clk);
        #1 update = 1'b0;
        if (m_pending) begin
            m_data    = m_rx;
            m_pending = 1'b0;
        end
        @(negedge clk);
        check("data_after_update", 64'(data), 64'(m_data));
    endtask

    function automatic void mk_frame(output byte_t q[$]);
        byte_t x;
        q.delete();
        x = 8'h00;
        for (int k = 0; k < FB; k++) begin
            q.push_back(byte_t'($urandom_range(255, 0)));
            x ^= q[k];
        end
        if (CSUM) q.push_back(x);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_t f[$];
        int    cls, mode, extra;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", 64'(data), 64'd0);
        check("rst_spiOut", {63'd0, spiOut}, 64'd0);
        check("rst_frame_ok", {63'd0, frame_ok}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // directed 11..66 (+77 checksum)
        f = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        if (CSUM) f.push_back(8'h77);
        send_frame(f, 0, 0);
        do_update();
        check("frame1_data", 64'(data), 64'h112233445566);

        // short frame
        f = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        send_frame(f, 0, 0);
        do_update();

        // one byte too many
        mk_frame(f);
        f.push_back(8'h5A);
        send_frame(f, 0, 0);
        do_update();

        // partial trailing byte
        mk_frame(f);
        send_frame(f, 3, 0);
        do_update();

        // two good frames without update: newest wins
        mk_frame(f);
        send_frame(f, 0, 0);
        mk_frame(f);
        send_frame(f, 0, 0);
        do_update();

        // pending frame committed by update overlapping next frame's first bit
        mk_frame(f);
        send_frame(f, 0, 0);
        mk_frame(f);
        send_frame(f, 0, 1);
        do_update();

        // update coinciding with a byte write of a new frame
        mk_frame(f);
        send_frame(f, 0, 2);
        do_update();

        // trailing 00 (bad checksum with checksum; overflow without)
        f = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
        send_frame(f, 0, 0);
        do_update();

        // randomized frames
        for (int it = 0; it < 24; it++) begin
            mk_frame(f);
            cls   = $urandom_range(4, 0);
            mode  = $urandom_range(2, 0);
            extra = 0;
            case (cls)
                1: void'(f.pop_back());
                2: f.push_back(byte_t'($urandom_range(255, 0)));
                3: extra = $urandom_range(7, 1);
                4: f[f.size()-1] = f[f.size()-1] ^ 8'h01;
                default: ;
            endcase
            send_frame(f, extra, mode);
            if ($urandom_range(1, 0) == 1) do_update();
        end

        // make data nonzero, then reset in the middle of a byte
        mk_frame(f);
        send_frame(f, 0, 0);
        do_update();
        spi_bit(1'b1, 1'b0);
        spi_bit(1'b0, 1'b0);
        spi_bit(1'b1, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check("midrst_data", 64'(data), 64'd0);
        check("midrst_spiOut", {63'd0, spiOut}, 64'd0);
        check("midrst_frame_ok", {63'd0, frame_ok}, 64'd0);
        check("midrst_frame_err", {63'd0, frame_err}, 64'd0);
        #1 reset = 1'b0;
        repeat (TO + 16) @(posedge clk);
        do_update();

        // good frame after reset still works
        mk_frame(f);
        send_frame(f, 0, 0);
        do_update();

        check("verdicts_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
